axi_stall_scheduler: RTL

- Per-channel stall scheduler for the five AXI handshakes: AW, W, AR, B, R.
- Decides, for each channel, when a pending beat may pass, and drives one gate enable per channel. A gate sits on that channel's valid/ready pair.
- Each channel's delay is either a fixed count or a pseudo-random count. Delays are configured at runtime per channel through a simple write port.
- Used in testbench and synthesizable delay fabrics in place of static delay parameters.

---
 rtl/axi_stall_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/axi_stall_scheduler.sv
// axi_stall_scheduler
//   Per-channel stall scheduler for the five AXI handshakes (AW, W, AR, B, R).
//   Each channel owns a small IDLE/COUNT/RELEASE FSM that holds its gate closed
//   for an effective delay. The delay is either a fixed configured count or a
//   pseudo-random count: a shared 16-bit Galois LFSR value, rotated per channel
//   and masked by the configured delay.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clr_i            synchronous clear of FSMs, counters and LFSR (config kept)
//   enable_i         0 opens every gate and parks the FSMs in IDLE
//   cfg_we_i         configuration write strobe
//   cfg_ch_i         target channel 0=AW 1=W 2=AR 3=B 4=R (5..7 ignored)
//   cfg_delay_i      fixed delay, or bound mask in random mode
//   cfg_random_i     1 selects random mode for the target channel
//   valid_i[4:0]     upstream valid per channel
//   ready_i[4:0]     downstream ready per channel, as seen at the gate
//   go_o[4:0]        gate enable per channel
//   stalled_o[4:0]   valid_i & ~go_o
module axi_stall_scheduler #(
  parameter int unsigned DelayWidth    = 8,
  parameter int unsigned DefaultDelay  = 1,
  parameter logic        DefaultRandom = 1'b0,
  parameter logic [15:0] LfsrSeed      = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  enable_i,
  input  logic                  cfg_we_i,
  input  logic [2:0]            cfg_ch_i,
  input  logic [DelayWidth-1:0] cfg_delay_i,
  input  logic                  cfg_random_i,
  input  logic [4:0]            valid_i,
  input  logic [4:0]            ready_i,
  output logic [4:0]            go_o,
  output logic [4:0]            stalled_o
);

  localparam int NumCh = 5;

  typedef enum logic [1:0] {IDLE, COUNT, RELEASE} state_e;

  logic [15:0] lfsr_q;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Rotate left by s: the upper half of the doubled word shifted left.
  function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] s);
    logic [31:0] d;
    d = {v, v} << s;
    return d[31:16];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else if (clr_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    localparam logic [3:0] Rot = 4'(3 * g);

    state_e                state_q;
    logic [DelayWidth-1:0] cnt_q;
    logic [DelayWidth-1:0] cfg_delay_q;
    logic                  cfg_random_q;
    logic [15:0]           lfsr_rot;
    logic [DelayWidth-1:0] eff;

    // Rotating by a different amount per channel decorrelates the channels
    // while sharing one LFSR.
    assign lfsr_rot = rotl16(lfsr_q, Rot);
    assign eff      = cfg_random_q ? (lfsr_rot[DelayWidth-1:0] & cfg_delay_q) : cfg_delay_q;

    // Gate: forced open when disabled; in IDLE a zero delay passes the beat
    // in the same cycle.
    assign go_o[g] = !enable_i ? 1'b1
                   : ((state_q == RELEASE) || ((state_q == IDLE) && (eff == '0)));

    // Config writes are independent of clear; in-flight beats already latched
    // their count, so a new value only matters at the next IDLE evaluation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cfg_delay_q  <= DelayWidth'(DefaultDelay);
        cfg_random_q <= DefaultRandom;
      end else if (cfg_we_i && (cfg_ch_i == 3'(g))) begin
        cfg_delay_q  <= cfg_delay_i;
        cfg_random_q <= cfg_random_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (clr_i || !enable_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (valid_i[g]) begin
              if (eff == DelayWidth'(1)) begin
                state_q <= RELEASE;
              end else if (eff != '0) begin
                cnt_q   <= eff - DelayWidth'(1);
                state_q <= COUNT;
              end
            end
          end
          // A beat is already pending here, so valid is not looked at.
          COUNT: begin
            if (cnt_q == DelayWidth'(1)) begin
              cnt_q   <= '0;
              state_q <= RELEASE;
            end else begin
              cnt_q <= cnt_q - DelayWidth'(1);
            end
          end
          // Hold the gate open until the beat actually transfers, even if
          // valid is withdrawn in between.
          RELEASE: begin
            if (valid_i[g] && ready_i[g]) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign stalled_o = valid_i & ~go_o;

endmodule
